// File: rtl/conv_pkg.sv
// Shared definitions for the image-filter sequencer: FSM encoding, widths,
// tap/output counts and byte-index helpers for the packed image and kernel.
// No logic; imported by conv_mac and conv_sched.
package conv_pkg;

  localparam int PIX_W       = 8;
  localparam int ACC_W       = 20;

  localparam int TAPS22      = 4;
  localparam int TAPS33      = 9;
  localparam int NUM_OUT     = 4;
  localparam int CALC_CYCLES = NUM_OUT * (TAPS22 + TAPS33);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit offset of pixel p(r,c) in the 4x4 image: 8*(4r+c).
  function automatic logic [6:0] pix_idx(input logic [1:0] r, input logic [1:0] c);
    return {r, c, 3'b000};
  endfunction

  // Bit offset of kernel tap k(i,j) in the 3x3 kernel: 8*(3i+j).
  function automatic logic [6:0] ker_idx(input logic [1:0] i, input logic [1:0] j);
    logic [3:0] t;
    t = ({2'b00, i} * 4'd3) + {2'b00, j};
    return {t, 3'b000};
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Single 8x8 multiply-accumulate: combinational product, registered accumulator.
// Latency: res is combinational on the current acc + a*b; acc updates next edge.
// Backpressure: none; advances whenever en is high.
//
// Ports: clk, rst (async active-low), clr (zero acc), en (accumulate this cycle),
//        last (final tap: acc reloads 0), a/b operands, res = fmt(acc + a*b).
// CONV_SAT_EN defined: res saturates to all-ones; undefined: res wraps (low byte).
module conv_mac
  import conv_pkg::*;
#(
  parameter int PIX_W = conv_pkg::PIX_W,
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             last,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] res
);

  logic [2*PIX_W-1:0] prod;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;

  always_comb begin
    prod = a * b;
    sum  = acc + ACC_W'(prod);
  end

`ifdef CONV_SAT_EN
  // Any bit above the result byte means the true value exceeds 255.
  always_comb res = ((sum >> PIX_W) != '0) ? '1 : sum[PIX_W-1:0];
`else
  always_comb res = sum[PIX_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      // The finished sum leaves through res; start the next output from zero.
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Job sequencer: latches a 4x4 image and 3x3 kernel, then runs 2x2/s2 and 3x3/s1
// convolutions on one shared MAC. Latency: done 53 cycles after the start edge.
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
//
// Ports: clk, rst (async active-low), start, data[127:0] image, filter[71:0] kernel,
//        busy, done (1-cycle pulse), state (IDLE/LOAD/CALC/DONE = 0..3),
//        ret22/ret33 result bytes at [8*(2oy+ox)+:8].
// Build option CONV_SAT_EN selects saturating result bytes (see conv_mac).
module conv_sched
  import conv_pkg::*;
#(
  parameter int PIX_W = conv_pkg::PIX_W,
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [16*PIX_W-1:0] data,
  input  logic [9*PIX_W-1:0]  filter,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state,
  output logic [4*PIX_W-1:0] ret22,
  output logic [4*PIX_W-1:0] ret33
);

  state_t st, st_nxt;

  logic [16*PIX_W-1:0] img;
  logic [9*PIX_W-1:0]  ker;

  // phase 0 = ret22, phase 1 = ret33; oidx = {oy, ox}; (ti,tj) = kernel tap.
  logic       phase;
  logic [1:0] oidx;
  logic [1:0] ti, tj;
  logic [3:0] tap;
  logic [5:0] cyc;

  logic       in_calc;
  logic       last_tap;
  logic       calc_end;
  logic [1:0] tj_max;
  logic [1:0] row, col;
  logic [PIX_W-1:0] pix, kv, res;

  always_comb begin
    in_calc  = (st == ST_CALC);
    last_tap = (tap == (phase ? 4'(TAPS33 - 1) : 4'(TAPS22 - 1)));
    tj_max   = phase ? 2'd2 : 2'd1;
    // A single cycle counter ends CALC; it coincides with phase 1's final tap.
    calc_end = in_calc && (cyc == 6'(CALC_CYCLES - 1));
    if (phase) begin
      row = {1'b0, oidx[1]} + ti;
      col = {1'b0, oidx[0]} + tj;
    end else begin
      row = {oidx[1], ti[0]};
      col = {oidx[0], tj[0]};
    end
    pix = img[pix_idx(row, col) +: PIX_W];
    kv  = ker[ker_idx(ti, tj) +: PIX_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= ST_IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (start) st_nxt = ST_LOAD;
      ST_LOAD: st_nxt = ST_CALC;
      ST_CALC: if (calc_end) st_nxt = ST_DONE;
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    state = st;
    busy  = (st != ST_IDLE);
    done  = (st == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img <= '0;
      ker <= '0;
    end else if (st == ST_LOAD) begin
      img <= data;
      ker <= filter;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      oidx  <= '0;
      ti    <= '0;
      tj    <= '0;
      tap   <= '0;
      cyc   <= '0;
    end else if (st == ST_LOAD) begin
      phase <= 1'b0;
      oidx  <= '0;
      ti    <= '0;
      tj    <= '0;
      tap   <= '0;
      cyc   <= '0;
    end else if (in_calc) begin
      cyc <= cyc + 6'd1;
      if (last_tap) begin
        ti   <= '0;
        tj   <= '0;
        tap  <= '0;
        oidx <= oidx + 2'd1;
        if (oidx == 2'(NUM_OUT - 1)) phase <= ~phase;
      end else begin
        tap <= tap + 4'd1;
        if (tj == tj_max) begin
          tj <= '0;
          ti <= ti + 2'd1;
        end else begin
          tj <= tj + 2'd1;
        end
      end
    end
  end

  conv_mac #(
    .PIX_W(PIX_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (st == ST_LOAD),
    .en  (in_calc),
    .last(last_tap),
    .a   (pix),
    .b   (kv),
    .res (res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret22 <= '0;
      ret33 <= '0;
    end else if (st == ST_LOAD) begin
      ret22 <= '0;
      ret33 <= '0;
    end else if (in_calc && last_tap) begin
      if (phase) ret33[{oidx, 3'b000} +: PIX_W] <= res;
      else       ret22[{oidx, 3'b000} +: PIX_W] <= res;
    end
  end

endmodule
